// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: period modes, fixed control/guard symbols, popcount helper.
// Combinational only; no latency or flow control of its own.
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_GUARD = 2'd2,
    MODE_RSVD  = 2'd3
  } tmds_mode_e;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_CH02 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1  = 10'b0100110011;

  // Stage-1 result handed to the DC-balance stage.
  typedef struct packed {
    logic [8:0] q_m;
    logic [3:0] n1q;
    tmds_mode_e mode;
    logic [1:0] ctrl;
  } qm_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Stage 1: transition-minimised q_m and its ones count, registered with mode/ctrl.
// Latency 1 enabled cycle; holds everything while i_ce is low, no backpressure.
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  output qm_t        o_qm
);

  logic [3:0] w_n1;
  logic       w_use_xnor;
  logic [8:0] w_q_m;
  qm_t        r_qm;

  always_comb begin
    w_n1       = popcount8(i_data);
    w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !i_data[0]);
    w_q_m      = '0;
    w_q_m[0]   = i_data[0];
    for (int i = 1; i < 8; i++) begin
      w_q_m[i] = w_use_xnor ? ~(w_q_m[i-1] ^ i_data[i]) : (w_q_m[i-1] ^ i_data[i]);
    end
    // q_m[8] tells the receiver which chain was used (1 = XOR).
    w_q_m[8] = ~w_use_xnor;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_qm <= '{q_m: '0, n1q: '0, mode: MODE_CTRL, ctrl: 2'b00};
    end else if (i_ce) begin
      r_qm <= '{q_m: w_q_m, n1q: popcount8(w_q_m[7:0]), mode: tmds_mode_e'(i_mode), ctrl: i_ctrl};
    end
  end

  assign o_qm = r_qm;

endmodule

// File: rtl/tmds_encoder.sv
// One-lane TMDS 8b/10b encoder: stage 1 transition minimisation, stage 2 DC balance.
// Latency 2 enabled cycles; all state including cnt and o_word holds while i_ce is low.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [1:0] i_mode,
  input  logic [7:0] i_data,
  input  logic [1:0] i_ctrl,
  output logic [9:0] o_word
);

  qm_t               w_qm;
  logic              w_q8;
  logic [7:0]        w_qm_byte;
  logic signed [5:0] w_d;
  logic signed [5:0] w_two_q8;
  logic signed [5:0] w_two_nq8;
  logic signed [5:0] w_cnt_nxt;
  logic [9:0]        w_word_nxt;
  logic signed [5:0] r_cnt;
  logic [9:0]        r_word;

  tmds_qm_stage u_qm_stage (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_mode    (i_mode),
    .i_data    (i_data),
    .i_ctrl    (i_ctrl),
    .o_qm      (w_qm)
  );

  always_comb begin
    w_q8       = w_qm.q_m[8];
    w_qm_byte  = w_qm.q_m[7:0];
    // d = ones - zeros of q_m[7:0] = 2*n1q - 8
    w_d        = $signed({1'b0, w_qm.n1q, 1'b0}) - 6'sd8;
    w_two_q8   = $signed({3'b000, w_q8, 1'b0});
    w_two_nq8  = $signed({3'b000, ~w_q8, 1'b0});
    w_word_nxt = ctrl_token(w_qm.ctrl);
    w_cnt_nxt  = 6'sd0;
    case (w_qm.mode)
      MODE_VIDEO: begin
        if ((r_cnt == 6'sd0) || (w_d == 6'sd0)) begin
          w_word_nxt = {~w_q8, w_q8, w_q8 ? w_qm_byte : ~w_qm_byte};
          w_cnt_nxt  = w_q8 ? (r_cnt + w_d) : (r_cnt - w_d);
        end else if (r_cnt[5] == w_d[5]) begin
          // Both nonzero with equal sign: invert to pull disparity back.
          w_word_nxt = {1'b1, w_q8, ~w_qm_byte};
          w_cnt_nxt  = r_cnt + w_two_q8 - w_d;
        end else begin
          w_word_nxt = {1'b0, w_q8, w_qm_byte};
          w_cnt_nxt  = r_cnt + w_d - w_two_nq8;
        end
      end
      MODE_GUARD: begin
        w_word_nxt = (CHANNEL == 1) ? GUARD_CH1 : GUARD_CH02;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word <= CTRL_TOKEN_00;
      r_cnt  <= 6'sd0;
    end else if (i_ce) begin
      r_word <= w_word_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_word = r_word;

endmodule
